// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory
//                responder: FSM state encoding, the NOP word returned for
//                out-of-range fetches, and the array index-width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0;

    // Latency counter width; holds READ_LATENCY-1 for latencies up to 7.
    localparam int CNT_W = 3;

    // Word-index width of an array of depth_words entries.
    function automatic int calc_idxw(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder_if
//  Description : Bus bundle between the fetch stage / program loader and the
//                instruction-memory responder.
//  Ports       : read port  - im_read_address, im_write_enable, im_write_data
//                             (to responder); im_read_data, im_stall_c,
//                             im_fault (from responder)
//                loader     - ld_valid, ld_addr, ld_data, ld_done (to
//                             responder); ld_ready (from responder)
//                modports   - master (fetch/loader side), slave (responder)
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic [ADDRESS_SIZE-1:0] im_read_address;
    logic                    im_write_enable;
    logic [DATA_SIZE-1:0]    im_write_data;
    logic [DATA_SIZE-1:0]    im_read_data;
    logic                    im_stall_c;
    logic                    im_fault;

    logic                    ld_valid;
    logic                    ld_ready;
    logic [ADDRESS_SIZE-1:0] ld_addr;
    logic [DATA_SIZE-1:0]    ld_data;
    logic                    ld_done;

    modport master (
        output im_read_address, im_write_enable, im_write_data,
        output ld_valid, ld_addr, ld_data, ld_done,
        input  im_read_data, im_stall_c, im_fault, ld_ready
    );

    modport slave (
        input  im_read_address, im_write_enable, im_write_data,
        input  ld_valid, ld_addr, ld_data, ld_done,
        output im_read_data, im_stall_c, im_fault, ld_ready
    );
endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_array
//  Description : DEPTH_WORDS x DATA_SIZE instruction word store. One write
//                port shared between the loader (while loading) and the
//                pipeline (otherwise); one combinational read port.
//                Contents are not reset.
//  Ports       : clock               rising-edge clock
//                sel_loader          1 = loader owns the write port
//                ld_we/ld_idx/ld_wdata  loader write request
//                pl_we/pl_idx/pl_wdata  pipeline write request
//                rd_idx / rd_data    combinational read
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_SIZE   = 32,
    parameter int IDXW        = 10
) (
    input  logic                 clock,
    input  logic                 sel_loader,
    input  logic                 ld_we,
    input  logic [IDXW-1:0]      ld_idx,
    input  logic [DATA_SIZE-1:0] ld_wdata,
    input  logic                 pl_we,
    input  logic [IDXW-1:0]      pl_idx,
    input  logic [DATA_SIZE-1:0] pl_wdata,
    input  logic [IDXW-1:0]      rd_idx,
    output logic [DATA_SIZE-1:0] rd_data
);
    logic [DATA_SIZE-1:0] mem_q [DEPTH_WORDS];

    logic                 wr_en;
    logic [IDXW-1:0]      wr_idx;
    logic [DATA_SIZE-1:0] wr_data;

    always_comb begin
        if (sel_loader) begin
            wr_en   = ld_we;
            wr_idx  = ld_idx;
            wr_data = ld_wdata;
        end else begin
            wr_en   = pl_we;
            wr_idx  = pl_idx;
            wr_data = pl_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Instruction-memory responder for the fetch read port. Loads a
//                program image over a valid/ready port, then serves fetches
//                with a READ_LATENCY+1 cycle miss penalty signalled through
//                im_stall_c. A one-entry tag/data register returns hits with
//                no stall. Out-of-range addresses set the sticky im_fault and
//                return NOP_WORD.
//  Ports       : clock    rising-edge clock
//                reset_n  synchronous active-low reset
//                bus      imem_responder_if.slave (read port + loader)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    imem_responder_if.slave bus
);
    localparam int               IDXW       = calc_idxw(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(READ_LATENCY - 1);

    imem_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [ADDRESS_SIZE-1:0] tag_q, tag_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    fault_q, fault_d;

    logic                    rd_oor, ld_oor, tag_oor;
    logic                    hit, wr_hits_tag;
    logic                    ld_we, pl_we;
    logic [DATA_SIZE-1:0]    array_word;
    logic [1:0]              unused_ld_low;

    assign unused_ld_low = bus.ld_addr[1:0];

    // Any address bit above the word index makes the address out of range.
    generate
        if (ADDRESS_SIZE > IDXW + 2) begin : g_range_check
            assign rd_oor  = |bus.im_read_address[ADDRESS_SIZE-1:IDXW+2];
            assign ld_oor  = |bus.ld_addr[ADDRESS_SIZE-1:IDXW+2];
            assign tag_oor = |tag_q[ADDRESS_SIZE-1:IDXW+2];
        end else begin : g_no_range_check
            assign rd_oor  = 1'b0;
            assign ld_oor  = 1'b0;
            assign tag_oor = 1'b0;
        end
    endgenerate

    assign hit         = valid_q && (bus.im_read_address == tag_q);
    assign wr_hits_tag = (state_q != LOAD) && bus.im_write_enable
                         && (bus.im_read_address == tag_q);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_SIZE   (DATA_SIZE),
        .IDXW        (IDXW)
    ) u_array (
        .clock      (clock),
        .sel_loader (state_q == LOAD),
        .ld_we      (ld_we),
        .ld_idx     (bus.ld_addr[IDXW+1:2]),
        .ld_wdata   (bus.ld_data),
        .pl_we      (pl_we),
        .pl_idx     (bus.im_read_address[IDXW+1:2]),
        .pl_wdata   (bus.im_write_data),
        .rd_idx     (tag_q[IDXW+1:2]),
        .rd_data    (array_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fault_d = fault_q;
        ld_we   = 1'b0;
        pl_we   = 1'b0;

        case (state_q)
            LOAD: begin
                // ld_ready is 1 throughout LOAD, so ld_valid alone is a handshake.
                if (bus.ld_valid) begin
                    if (ld_oor) begin
                        fault_d = 1'b1;
                    end else begin
                        ld_we = 1'b1;
                    end
                end
                if (bus.ld_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!hit) begin
                    tag_d   = bus.im_read_address;
                    valid_d = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.im_read_address != tag_q) begin
                    tag_d = bus.im_read_address;
                    cnt_d = CNT_RELOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (wr_hits_tag) begin
                    // The word is being rewritten this cycle; wait it out again.
                    cnt_d = CNT_RELOAD;
                end else begin
                    data_d  = tag_oor ? DATA_SIZE'(NOP_WORD) : array_word;
                    fault_d = fault_q | tag_oor;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Pipeline writes outside LOAD; a write to the held tag forces a refetch.
        if (state_q != LOAD && bus.im_write_enable) begin
            pl_we = !rd_oor;
            if (wr_hits_tag) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign bus.ld_ready     = (state_q == LOAD);
    assign bus.im_stall_c   = (state_q != IDLE) || !hit;
    assign bus.im_read_data = data_q;
    assign bus.im_fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Scoreboard bench for imem_responder. The driver issues
//                fetches, restarts, pipeline writes and loader traffic and
//                pushes the expected response (word, stalled-cycle count,
//                fault flag) computed from a word-array model; a monitor pops
//                and compares whenever the DUT drops im_stall_c.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 1024;
    localparam int RL      = 2;
    localparam int PENALTY = RL + 1;

    typedef struct {
        logic [31:0] data;
        int          stalls;
        bit          fault;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    imem_responder_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

    imem_responder #(
        .ADDRESS_SIZE (AW),
        .DATA_SIZE    (DW),
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int          n_tests;
    int          n_fail;
    exp_t        sb[$];
    logic [31:0] mem_m [DEPTH];
    bit          fault_m;
    bit          mon_en;
    int          mon_stall_cnt;
    logic [31:0] cur_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit oor(input logic [31:0] a);
        return a >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        return oor(a) ? 32'h0 : mem_m[int'(a / 4)];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd);
        if (!oor(a)) mem_m[int'(a / 4)] = wd;
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_oor, input logic [31:0] avoid);
        logic [31:0] a;
        do begin
            if (allow_oor && $urandom_range(0, 3) == 0)
                a = (32'h1000 << $urandom_range(0, 19)) | ($urandom & 32'hFFF);
            else
                a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        end while (a == avoid);
        return a;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t        e;
        bit          have_last;
        logic [31:0] last_data;
        have_last     = 1'b0;
        last_data     = '0;
        mon_stall_cnt = 0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                mon_stall_cnt = 0;
                have_last     = 1'b0;
            end else if (bus.im_stall_c) begin
                mon_stall_cnt++;
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                check("read_data", bus.im_read_data, e.data);
                check("stall_cycles", 32'(mon_stall_cnt), 32'(e.stalls));
                check("fault", {31'b0, bus.im_fault}, {31'b0, e.fault});
                check("ld_ready_outside_load", {31'b0, bus.ld_ready}, 32'h0);
                last_data     = bus.im_read_data;
                have_last     = 1'b1;
                mon_stall_cnt = 0;
            end else if (have_last) begin
                check("hold_data", bus.im_read_data, last_data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL response_timeout: got %0d outstanding after %0d cycles, expected 0", sb.size(), n);
            sb.delete();
        end
        #1;
    endtask

    task automatic hold(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    task automatic issue_read(input logic [31:0] a, input bit do_wr, input logic [31:0] wd);
        exp_t e;
        if (do_wr) model_write(a, wd);
        fault_m  = fault_m | oor(a);
        e.data   = expect_word(a);
        e.stalls = PENALTY;
        e.fault  = fault_m;
        sb.push_back(e);
        bus.im_read_address = a;
        bus.im_write_enable = do_wr;
        bus.im_write_data   = wd;
        cur_addr = a;
        @(posedge clock);
        #1;
        bus.im_write_enable = 1'b0;
        wait_done();
    endtask

    // Address a misses, then after k stalled cycles the fetch moves to b.
    task automatic restart_read(input logic [31:0] a, input logic [31:0] b, input int k);
        exp_t e;
        fault_m  = fault_m | oor(b);
        e.data   = expect_word(b);
        e.stalls = k + PENALTY;
        e.fault  = fault_m;
        sb.push_back(e);
        bus.im_read_address = a;
        repeat (k) @(posedge clock);
        #1;
        bus.im_read_address = b;
        cur_addr = b;
        wait_done();
    endtask

    task automatic write_at_hit(input logic [31:0] wd);
        exp_t e;
        bus.im_write_enable = 1'b1;
        bus.im_write_data   = wd;
        @(posedge clock);
        #1;
        bus.im_write_enable = 1'b0;
        model_write(cur_addr, wd);
        e.data   = expect_word(cur_addr);
        e.stalls = PENALTY;
        e.fault  = fault_m;
        sb.push_back(e);
        wait_done();
    endtask

    task automatic random_phase(input int n, input bit allow_oor);
        for (int i = 0; i < n; i++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] b;
            kind = $urandom_range(0, 4);
            // Loader traffic outside LOAD must have no effect.
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_addr  = 32'($urandom_range(0, 15)) * 4;
            bus.ld_data  = $urandom;
            bus.ld_done  = 1'($urandom_range(0, 1));
            case (kind)
                0, 1: issue_read(rand_addr(allow_oor, cur_addr), 1'b0, 32'h0);
                2: begin
                    a = rand_addr(1'b0, cur_addr);
                    issue_read(a, 1'b1, $urandom);
                end
                3: begin
                    a = rand_addr(allow_oor, cur_addr);
                    b = rand_addr(allow_oor, a);
                    restart_read(a, b, $urandom_range(1, RL));
                end
                default: begin
                    if (!oor(cur_addr)) write_at_hit($urandom);
                    else issue_read(rand_addr(1'b0, cur_addr), 1'b0, 32'h0);
                end
            endcase
            hold($urandom_range(0, 2));
        end
        bus.ld_valid = 1'b0;
        bus.ld_done  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] word;
        logic [31:0] a;
        n_tests = 0;
        n_fail  = 0;
        fault_m = 1'b0;
        mon_en  = 1'b0;
        cur_addr = 32'h0;
        reset_n = 1'b0;
        bus.im_read_address = 32'h0;
        bus.im_write_enable = 1'b0;
        bus.im_write_data   = 32'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        bus.ld_data  = 32'h0;
        bus.ld_done  = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_ld_ready", {31'b0, bus.ld_ready}, 32'h1);
        check("reset_stall", {31'b0, bus.im_stall_c}, 32'h1);
        check("reset_data", bus.im_read_data, 32'h0);
        check("reset_fault", {31'b0, bus.im_fault}, 32'h0);
        reset_n = 1'b1;

        // Program load; pipeline write strobe to word 0 during LOAD must be ignored.
        for (int i = 0; i < 16; i++) begin
            word = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h2009_0003 : $urandom;
            mem_m[i] = word;
            repeat ($urandom_range(0, 2)) begin
                bus.ld_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 32'(i) * 4;
            bus.ld_data  = word;
            bus.ld_done  = (i == 15);
            if (i == 1) begin
                bus.im_write_enable = 1'b1;
                bus.im_read_address = 32'h0;
                bus.im_write_data   = 32'hBAD0_BAD0;
            end
            if (i == 0) check("load_ld_ready", {31'b0, bus.ld_ready}, 32'h1);
            @(posedge clock);
            #1;
        end
        bus.ld_valid = 1'b0;
        bus.ld_done  = 1'b0;
        bus.im_write_enable = 1'b0;
        check("after_done_ld_ready", {31'b0, bus.ld_ready}, 32'h0);
        check("after_load_fault", {31'b0, bus.im_fault}, 32'h0);

        mon_en = 1'b1;
        issue_read(32'h0, 1'b0, 32'h0);          // first fetch after load
        hold(2);
        issue_read(32'h4, 1'b0, 32'h0);          // new address, then hold
        hold(3);
        restart_read(32'h0, 32'h4, 2);           // address change mid-miss
        hold(1);
        write_at_hit(32'hDEAD_BEEF);             // write to held tag forces refetch
        hold(1);

        random_phase(30, 1'b0);

        issue_read(32'h0000_1000, 1'b0, 32'h0);  // out-of-range fetch -> NOP + fault
        hold(2);

        random_phase(30, 1'b1);

        // Reset while a miss is in flight.
        mon_en = 1'b0;
        bus.im_write_enable = 1'b0;
        a = rand_addr(1'b0, cur_addr);
        bus.im_read_address = a;
        cur_addr = a;
        @(posedge clock);
        #1;
        check("busy_stall", {31'b0, bus.im_stall_c}, 32'h1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        fault_m = 1'b0;
        check("midbusy_reset_ld_ready", {31'b0, bus.ld_ready}, 32'h1);
        check("midbusy_reset_stall", {31'b0, bus.im_stall_c}, 32'h1);
        check("midbusy_reset_data", bus.im_read_data, 32'h0);
        check("midbusy_reset_fault", {31'b0, bus.im_fault}, 32'h0);

        // Out-of-range loader word is dropped and raises the fault.
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_2000;
        bus.ld_data  = $urandom;
        bus.ld_done  = 1'b0;
        @(posedge clock);
        #1;
        fault_m = 1'b1;
        check("load_oor_fault", {31'b0, bus.im_fault}, 32'h1);
        check("load_oor_ld_ready", {31'b0, bus.ld_ready}, 32'h1);
        bus.ld_valid = 1'b0;
        bus.ld_done  = 1'b1;
        @(posedge clock);
        #1;
        bus.ld_done = 1'b0;

        mon_en = 1'b1;
        issue_read(32'h0, 1'b0, 32'h0);          // array contents survive reset
        hold(2);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        check("no_stray_stall", 32'(mon_stall_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
